out_fm_fifo_to_ram: RTL and testbench

//  Drains one Tm x Tr x Tc output-feature-map tile from the out_fm FIFO and writes it back to RAM

---
 rtl/out_fm_fifo_to_ram_pkg.sv | 20 ++
 rtl/out_fm_fifo_to_ram_if.sv | 32 +++
 rtl/out_fm_fifo_to_ram_nest3_counter.sv | 49 ++++
 rtl/out_fm_fifo_to_ram.sv | 150 +++++++++++++++
 tb/tb_out_fm_fifo_to_ram.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/out_fm_fifo_to_ram_pkg.sv
// Shared tile geometry defaults and transfer FSM encoding for the out_fm / in_fm movers.
package out_fm_fifo_to_ram_pkg;

  localparam int DEF_M  = 32;
  localparam int DEF_R  = 64;
  localparam int DEF_C  = 32;
  localparam int DEF_TM = 8;
  localparam int DEF_TR = 16;
  localparam int DEF_TC = 8;

  localparam int DEF_TILE_WORDS = DEF_TM * DEF_TR * DEF_TC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } tile_state_t;

endpackage

// File: rtl/out_fm_fifo_to_ram_if.sv
// FIFO read side and RAM write side of the out_fm drain path.
interface out_fm_fifo_to_ram_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          fifo_pop;
  logic          fifo_empty;
  logic [DW-1:0] data_from_fifo;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] data_to_ram;

  modport master (
    output fifo_pop,
    input  fifo_empty,
    input  data_from_fifo,
    output ram_we,
    output ram_addr,
    output data_to_ram
  );

  modport slave (
    input  fifo_pop,
    output fifo_empty,
    output data_from_fifo,
    input  ram_we,
    input  ram_addr,
    input  data_to_ram
  );

endinterface

// File: rtl/out_fm_fifo_to_ram_nest3_counter.sv
// Three nested wrap counters (c0 fastest); 'last' flags the final index of the nest.
module nest3_counter #(
  parameter int CW = 32,
  parameter int N0 = 8,
  parameter int N1 = 16,
  parameter int N2 = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          clean,
  output logic [CW-1:0] c0,
  output logic [CW-1:0] c1,
  output logic [CW-1:0] c2,
  output logic          last
);

  logic wrap0_s, wrap1_s, wrap2_s;

  assign wrap0_s = (c0 == CW'(N0 - 1));
  assign wrap1_s = (c1 == CW'(N1 - 1));
  assign wrap2_s = (c2 == CW'(N2 - 1));
  assign last    = wrap0_s && wrap1_s && wrap2_s;

  always_ff @(posedge clk) begin
    if (rst || clean) begin
      c0 <= '0;
      c1 <= '0;
      c2 <= '0;
    end else if (ena) begin
      if (wrap0_s) begin
        c0 <= '0;
        if (wrap1_s) begin
          c1 <= '0;
          if (wrap2_s) begin
            c2 <= '0;
          end else begin
            c2 <= c2 + CW'(1);
          end
        end else begin
          c1 <= c1 + CW'(1);
        end
      end else begin
        c0 <= c0 + CW'(1);
      end
    end
  end

endmodule

// File: rtl/out_fm_fifo_to_ram.sv
// Drains one Tm x Tr x Tc output tile from the out_fm FIFO into row-major out_fm RAM.
// Optional build macro OUT_FM_RELU_EN clamps negative words to zero in the write stage.
module out_fm_fifo_to_ram
  import out_fm_fifo_to_ram_pkg::*;
#(
  parameter int CW = 32,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int M  = DEF_M,
  parameter int R  = DEF_R,
  parameter int C  = DEF_C,
  parameter int Tm = DEF_TM,
  parameter int Tr = DEF_TR,
  parameter int Tc = DEF_TC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          done,
  input  logic          conv_tile_clean,
  input  logic [CW-1:0] tile_base_m,
  input  logic [CW-1:0] tile_base_row,
  input  logic [CW-1:0] tile_base_col,
  out_fm_fifo_to_ram_if.master bus
);

  tile_state_t   state_r, state_s;
  logic [CW-1:0] base_m_r, base_row_r, base_col_r;
  logic [CW-1:0] tc_s, tr_s, tm_s;
  logic [CW:0]   m_idx_s, r_idx_s, c_idx_s;
  logic [AW-1:0] addr_s, addr_r;
  logic [DW-1:0] data_s;
  logic          last_s, pop_s, legal_s, we_r;

  function automatic logic [DW-1:0] write_word(input logic [DW-1:0] w);
`ifdef OUT_FM_RELU_EN
    if (w[DW-1]) begin
      write_word = '0;
    end else begin
      write_word = w;
    end
`else
    write_word = w;
`endif
  endfunction

  nest3_counter #(.CW(CW), .N0(Tc), .N1(Tr), .N2(Tm)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .ena   (pop_s),
    .clean (conv_tile_clean),
    .c0    (tc_s),
    .c1    (tr_s),
    .c2    (tm_s),
    .last  (last_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Clean overrides every other transition, including a coincident start.
  always_comb begin
    state_s = state_r;
    if (conv_tile_clean) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) state_s = ST_XFER;
          else       state_s = ST_IDLE;
        end
        ST_XFER: begin
          if (pop_s && last_s) state_s = ST_DRAIN;
          else                 state_s = ST_XFER;
        end
        ST_DRAIN: state_s = ST_DONE;
        ST_DONE:  state_s = ST_DONE;
        default:  state_s = ST_IDLE;
      endcase
    end
  end

  // Reset gates the pop combinationally so an aborted transfer leaves the FIFO untouched.
  always_comb begin
    pop_s = 1'b0;
    done  = 1'b0;
    if ((state_r == ST_XFER) && !bus.fifo_empty && !rst) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (state_r == ST_DONE) begin
      done = 1'b1;
    end else begin
      done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_m_r   <= '0;
      base_row_r <= '0;
      base_col_r <= '0;
    end else if ((state_r == ST_IDLE) && start && !conv_tile_clean) begin
      base_m_r   <= tile_base_m;
      base_row_r <= tile_base_row;
      base_col_r <= tile_base_col;
    end
  end

  assign m_idx_s = {1'b0, base_m_r}   + (CW+1)'(tm_s);
  assign r_idx_s = {1'b0, base_row_r} + (CW+1)'(tr_s);
  assign c_idx_s = {1'b0, base_col_r} + (CW+1)'(tc_s);

  assign legal_s = (m_idx_s < (CW+1)'(M)) && (r_idx_s < (CW+1)'(R)) && (c_idx_s < (CW+1)'(C));
  assign addr_s  = AW'(m_idx_s) * AW'(R * C) + AW'(r_idx_s) * AW'(C) + AW'(c_idx_s);

  // Write stage: address and enable follow the pop by one cycle, matching FIFO read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r   <= 1'b0;
      addr_r <= '0;
    end else begin
      we_r <= pop_s && legal_s;
      if (pop_s) begin
        addr_r <= addr_s;
      end
    end
  end

  always_comb begin
    data_s = '0;
    if (we_r) begin
      data_s = write_word(bus.data_from_fifo);
    end else begin
      data_s = '0;
    end
  end

  assign bus.fifo_pop    = pop_s;
  assign bus.ram_we      = we_r;
  assign bus.ram_addr    = addr_r;
  assign bus.data_to_ram = data_s;

endmodule

// File: tb/tb_out_fm_fifo_to_ram.sv
// Randomized self-checking bench for out_fm_fifo_to_ram against a tile-walk reference model.
module tb_out_fm_fifo_to_ram;

  localparam int M = 32, R = 64, C = 32, TM = 8, TR = 16, TC = 8;
  localparam int TILE = TM * TR * TC;

  logic        clk;
  logic        rst;
  logic        start;
  logic        done;
  logic        conv_tile_clean;
  logic [31:0] tile_base_m, tile_base_row, tile_base_col;

  out_fm_fifo_to_ram_if #(.AW(32), .DW(32)) bus ();

  out_fm_fifo_to_ram dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .done            (done),
    .conv_tile_clean (conv_tile_clean),
    .tile_base_m     (tile_base_m),
    .tile_base_row   (tile_base_row),
    .tile_base_col   (tile_base_col),
    .bus             (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  bit          stall_en = 1'b0;
  logic [31:0] forced[$];
  logic [31:0] pop_vals[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int cyc = 0, last_pop_cyc = -1, last_we_cyc = -1, done_cyc = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: hands out a fresh word one cycle after each pop.
  always @(posedge clk) begin
    logic [31:0] w;
    if (bus.fifo_pop) begin
      if (forced.size() > 0) w = forced.pop_front();
      else                   w = $urandom;
      pop_vals.push_back(w);
      bus.data_from_fifo <= w;
      last_pop_cyc = cyc;
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    bus.fifo_empty = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  always @(negedge clk) begin
    if (bus.ram_we) begin
      wr_addr.push_back(bus.ram_addr);
      wr_data.push_back(bus.data_to_ram);
      last_we_cyc = cyc;
    end
    if (done && done_cyc < 0) done_cyc = cyc;
  end

  function automatic logic [31:0] model_data(input logic [31:0] w);
`ifdef OUT_FM_RELU_EN
    return w[31] ? 32'h0 : w;
`else
    return w;
`endif
  endfunction

  task automatic check_tile(input string name, input int bm, input int br, input int bc);
    int n_exp = 0;
    compared++;
    if (pop_vals.size() !== TILE) begin
      mismatched++;
      $display("FAIL %s pop_count: got %0d want %0d", name, pop_vals.size(), TILE);
    end
    for (int k = 0; k < TILE && k < pop_vals.size(); k++) begin
      int m = k / (TR * TC);
      int r = (k / TC) % TR;
      int c = k % TC;
      if (bm + m < M && br + r < R && bc + c < C) begin
        logic [31:0] ea, ed;
        ea = 32'((bm + m) * R * C + (br + r) * C + bc + c);
        ed = model_data(pop_vals[k]);
        if (n_exp < wr_addr.size()) begin
          compared++;
          if (wr_addr[n_exp] !== ea || wr_data[n_exp] !== ed) begin
            mismatched++;
            $display("FAIL %s write[%0d]: got %h/%h want %h/%h", name, n_exp,
                     wr_addr[n_exp], wr_data[n_exp], ea, ed);
          end
        end
        n_exp++;
      end
    end
    compared++;
    if (wr_addr.size() !== n_exp) begin
      mismatched++;
      $display("FAIL %s write_count: got %0d want %0d", name, wr_addr.size(), n_exp);
    end
    compared++;
    if (done_cyc !== last_pop_cyc + 2) begin
      mismatched++;
      $display("FAIL %s done_timing: got cycle %0d want %0d", name, done_cyc, last_pop_cyc + 2);
    end
  endtask

  task automatic run_tile(input string name, input int bm, input int br, input int bc,
                          input bit stall, input bit do_clean);
    bit timeout = 1'b1;
    wr_addr.delete(); wr_data.delete(); pop_vals.delete();
    done_cyc = -1; last_pop_cyc = -1; last_we_cyc = -1;
    stall_en = stall;
    tile_base_m = 32'(bm); tile_base_row = 32'(br); tile_base_col = 32'(bc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done) begin timeout = 1'b0; break; end
    end
    @(negedge clk);
    stall_en = 1'b0;
    if (timeout) begin
      compared++; mismatched++;
      $display("FAIL %s done_timeout: got done=%b want 1", name, done);
    end else begin
      check_tile(name, bm, br, bc);
    end
    if (do_clean) begin
      conv_tile_clean = 1'b1;
      @(negedge clk); conv_tile_clean = 1'b0;
      compared++;
      if (done !== 1'b0) begin
        mismatched++;
        $display("FAIL %s done_after_clean: got %b want 0", name, done);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; conv_tile_clean = 1'b0;
    tile_base_m = 32'h0; tile_base_row = 32'h0; tile_base_col = 32'h0;
    repeat (3) @(negedge clk);
    compared++;
    if ({bus.ram_we, bus.fifo_pop, done} !== 3'b000 || bus.ram_addr !== 32'h0 ||
        bus.data_to_ram !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_outputs: got we=%b pop=%b done=%b addr=%h data=%h want all 0",
               bus.ram_we, bus.fifo_pop, done, bus.ram_addr, bus.data_to_ram);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_base_tile();
    run_tile("base", 0, 0, 0, 1'b0, 1'b1);
    compared++;
    if (wr_addr.size() !== TILE || done_cyc !== last_we_cyc + 1) begin
      mismatched++;
      $display("FAIL base_done_after_write: got writes=%0d done=%0d lastwe=%0d want %0d, lastwe+1",
               wr_addr.size(), done_cyc, last_we_cyc, TILE);
    end
  endtask

  task automatic test_edge_tile();
    run_tile("edge", 28, 56, 28, 1'b0, 1'b1);
    compared++;
    if (wr_addr.size() !== 128 || wr_addr[0] !== 32'd59164) begin
      mismatched++;
      $display("FAIL edge_first_addr: got n=%0d addr0=%0d want 128, 59164",
               wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : 32'hx);
    end
  endtask

  task automatic test_stall();
    run_tile("stall", 0, 0, 0, 1'b1, 1'b1);
  endtask

  task automatic test_random_tiles();
    for (int t = 0; t < 3; t++) begin
      run_tile($sformatf("rand%0d", t), int'($urandom_range(0, M - 1)),
               int'($urandom_range(0, R - 1)), int'($urandom_range(0, C - 1)),
               1'($urandom_range(0, 1)), 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    bit reached = 1'b0;
    pop_vals.delete();
    stall_en = 1'b0;
    tile_base_m = 32'h0; tile_base_row = 32'h0; tile_base_col = 32'h0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (pop_vals.size() >= 300) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if (!reached || {bus.ram_we, bus.fifo_pop, done} !== 3'b000 || pop_vals.size() !== 300) begin
      mismatched++;
      $display("FAIL rst_mid_abort: got we=%b pop=%b done=%b pops=%0d want 0 0 0 300",
               bus.ram_we, bus.fifo_pop, done, pop_vals.size());
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_tile("after_rst", 0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_clean_start();
    int pops;
    run_tile("pre_clean", 4, 8, 4, 1'b0, 1'b0);
    pops = pop_vals.size();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    compared++;
    if (done !== 1'b1 || pop_vals.size() !== pops) begin
      mismatched++;
      $display("FAIL start_in_done_ignored: got done=%b pops=%0d want 1 %0d", done, pop_vals.size(), pops);
    end
    conv_tile_clean = 1'b1; start = 1'b1;
    @(negedge clk); conv_tile_clean = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);
    compared++;
    if (done !== 1'b0 || pop_vals.size() !== pops || bus.ram_we !== 1'b0) begin
      mismatched++;
      $display("FAIL clean_beats_start: got done=%b pops=%0d we=%b want 0 %0d 0",
               done, pop_vals.size(), bus.ram_we, pops);
    end
  endtask

  task automatic test_sign_words();
    logic [31:0] e0, e1;
`ifdef OUT_FM_RELU_EN
    e0 = 32'h0000_0000;
`else
    e0 = 32'hFFFF_FFF6;
`endif
    e1 = 32'h0000_000A;
    forced.push_back(32'hFFFF_FFF6);
    forced.push_back(32'h0000_000A);
    run_tile("sign", 0, 0, 0, 1'b0, 1'b1);
    compared++;
    if (wr_data.size() < 2 || wr_data[0] !== e0 || wr_data[1] !== e1) begin
      mismatched++;
      $display("FAIL sign_words: got %h %h want %h %h",
               (wr_data.size() > 0) ? wr_data[0] : 32'hx,
               (wr_data.size() > 1) ? wr_data[1] : 32'hx, e0, e1);
    end
  endtask

  initial begin
    test_reset();
    test_base_tile();
    test_edge_tile();
    test_stall();
    test_random_tiles();
    test_reset_mid();
    test_clean_start();
    test_sign_words();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
